seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

- Reads back a time-multiplexed, active-low 4-digit seven-segment display bus (segments a–g plus 4 anode enables).
- Turns that bus into a 16-bit hex value, i.e. it is the inverse of the hex-to-segment driver.
- Sits on the display pins as a self-check / loopback monitor.
- Tracks each digit until it is stable, decodes it, and reports a complete frame once all four digits have been captured.

## Interface
Parameters:
- STABLE_CYCLES, 16, consecutive unchanged samples required before a digit is captured; legal range 2..65535.
- CNT_W, $clog2(STABLE_CYCLES+1), stability counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- seg  in  7  segment lines {a,b,c,d,e,f,g}, active-low (0 = lit), asynchronous to clk.
- an  in  4  anode enables, active-low; an[i]=0 selects digit i; asynchronous.
- value  out  16  last complete frame; digit i in value[4i+3:4i].
- err  out  4  err[i]=1 if digit i of the last frame was an unrecognised pattern.
- frame_valid  out  1  one-cycle pulse when value/err update.
- seen  out  4  digits captured so far in the current frame.

## Operation
- seg and an each pass through a 2-flop synchroniser. sseg/san denote the stage-2 outputs.
- A register p holds the previous {san,sseg}. The stability counter cnt clears whenever {san,sseg} != p, and increments otherwise, saturating.
- State machine:
  - IDLE: entered when san is not one-hot-low (0 or ≥2 anodes low). No counting.
  - TRACK: entered from IDLE or CAPTURED on any change to a one-hot-low san. When cnt == STABLE_CYCLES-1 with no change → capture, go to CAPTURED.
  - CAPTURED: held while the input is unchanged. Any change → TRACK (or IDLE if san is not one-hot-low).
- Capture of digit i:
  - Decode sseg against the 16 patterns: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - Match: store the nibble and clear its error bit.
  - No match (including blank 1111111): store nibble 0 and set its error bit.
  - Set seen[i]. Recapturing a digit already in seen overwrites its nibble/error bit; seen is unchanged.
- Frame completion:
  - When seen becomes 4'b1111 at an edge, the next edge does all of the following: copies the digit registers to value, copies the error bits to err, pulses frame_valid, and clears seen.
  - A capture arriving on that same edge sets its seen bit after the clear, so it counts toward the new frame.

## Timing
- Reset (async assert, sync release): value=0, err=0, frame_valid=0, seen=0, state IDLE, cnt=0, all synchronisers/digit registers 0.
- Let edge E be the first edge that samples a new pin pattern, held steady. Capture (seen[i] set) occurs at edge E+2+STABLE_CYCLES.
- frame_valid asserts for exactly one cycle, one edge after seen reaches 4'b1111.
- A glitch lasting fewer than STABLE_CYCLES samples restarts the count. No capture occurs for the glitch or for the pattern it interrupts.
- Reset asserted mid-frame: partial seen is discarded; value returns to 0.
- The decoder has no ready/backpressure. Frames are overwritten.

## Configuration
- SEG7_SCAN_DP_EN defined:
  - Adds input dp (1 bit, active-low) and output dp_out (4 bits).
  - dp is synchronised and included in the stability compare.
  - It is captured per digit and published to dp_out with value at frame completion (dp_out[i]=1 means lit). Reset value is 0.
- SEG7_SCAN_DP_EN undefined: no dp port or logic. Behaviour is otherwise identical.

## Structure
- Package seg7_pkg holds:
  - the 16 segment-pattern constants SEG7_0..SEG7_F and SEG7_BLANK;
  - NUM_DIGITS=4;
  - the state enum (IDLE/TRACK/CAPTURED).
- Sub-module seg7_pattern_decode: combinational, 7-bit seg in, {hit, nibble[3:0]} out, table taken from seg7_pkg.

## Test plan
- Drive an=1110/1101/1011/0111 with seg for 3,A,0,F, each held 20 cycles (STABLE_CYCLES=16) → one frame_valid pulse, value=16'hF0A3, err=0.
- Hold digit 0 steady for only 10 cycles, then 1111111 on digit 2 within a full scan → no capture from the 10-cycle hold; frame shows err=4'b0100 with value[11:8]=0.
- Assert an=1100 (two anodes) for 40 cycles → seen stays unchanged, no capture.
- Scan digit 1 twice with 5 then 7 before completing the frame → value[7:4]=7, exactly one frame_valid.
- Assert reset_n=0 after 3 digits are captured → all outputs 0 immediately; after release a full scan is needed before frame_valid.
- With SEG7_SCAN_DP_EN defined, dp low on digit 2 only → dp_out=4'b0100 at frame_valid.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, state type and helpers for the seven-segment readback decoder
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Segment patterns {a,b,c,d,e,f,g}, active-low (0 = lit)
    localparam logic [6:0] SEG7_0     = 7'b0000001;
    localparam logic [6:0] SEG7_1     = 7'b1001111;
    localparam logic [6:0] SEG7_2     = 7'b0010010;
    localparam logic [6:0] SEG7_3     = 7'b0000110;
    localparam logic [6:0] SEG7_4     = 7'b1001100;
    localparam logic [6:0] SEG7_5     = 7'b0100100;
    localparam logic [6:0] SEG7_6     = 7'b0100000;
    localparam logic [6:0] SEG7_7     = 7'b0001111;
    localparam logic [6:0] SEG7_8     = 7'b0000000;
    localparam logic [6:0] SEG7_9     = 7'b0000100;
    localparam logic [6:0] SEG7_A     = 7'b0001000;
    localparam logic [6:0] SEG7_B     = 7'b1100000;
    localparam logic [6:0] SEG7_C     = 7'b0110001;
    localparam logic [6:0] SEG7_D     = 7'b1000010;
    localparam logic [6:0] SEG7_E     = 7'b0110000;
    localparam logic [6:0] SEG7_F     = 7'b0111000;
    localparam logic [6:0] SEG7_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        CAPTURED
    } scan_state_t;

    function automatic logic one_hot_low(input logic [3:0] an);
        logic [3:0] sel;
        sel = ~an;
        return (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - maps an active-low segment pattern back to its hex nibble
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b1;
        nibble = 4'h0;
        case (seg)
            SEG7_0:     nibble = 4'h0;
            SEG7_1:     nibble = 4'h1;
            SEG7_2:     nibble = 4'h2;
            SEG7_3:     nibble = 4'h3;
            SEG7_4:     nibble = 4'h4;
            SEG7_5:     nibble = 4'h5;
            SEG7_6:     nibble = 4'h6;
            SEG7_7:     nibble = 4'h7;
            SEG7_8:     nibble = 4'h8;
            SEG7_9:     nibble = 4'h9;
            SEG7_A:     nibble = 4'hA;
            SEG7_B:     nibble = 4'hB;
            SEG7_C:     nibble = 4'hC;
            SEG7_D:     nibble = 4'hD;
            SEG7_E:     nibble = 4'hE;
            SEG7_F:     nibble = 4'hF;
            SEG7_BLANK: hit    = 1'b0;
            default:    hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - loopback monitor turning a scanned 4-digit display bus into a 16-bit value
// Optional decimal-point capture is enabled by defining SEG7_SCAN_DP_EN.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
`ifdef SEG7_SCAN_DP_EN
    input  logic        dp,
    output logic [3:0]  dp_out,
`endif
    output logic [15:0] value,
    output logic [3:0]  err,
    output logic        frame_valid,
    output logic [3:0]  seen
);

`ifdef SEG7_SCAN_DP_EN
    localparam int SW = 12;
`else
    localparam int SW = 11;
`endif
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SW-1:0]    pins, sync1, sync2, prev;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       sseg;
    logic [3:0]       san;
    logic             changed;
    logic             capture;
    logic             hit;
    logic [3:0]       nibble;
    logic [15:0]      dig_q;
    logic [3:0]       derr_q;
    logic [3:0]       sel;
    logic             frame_done;
    scan_state_t      state_q, state_d;

`ifdef SEG7_SCAN_DP_EN
    logic       sdp;
    logic [3:0] ddp_q;
    assign pins = {dp, an, seg};
    assign sdp  = sync2[11];
`else
    assign pins = {an, seg};
`endif

    assign sseg       = sync2[6:0];
    assign san        = sync2[10:7];
    assign sel        = ~san;
    assign changed    = (sync2 != prev);
    assign frame_done = (seen == 4'b1111);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            cnt     <= '0;
            state_q <= IDLE;
        end else begin
            sync1   <= pins;
            sync2   <= sync1;
            prev    <= sync2;
            state_q <= state_d;
            if (changed)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (changed) begin
            state_d = one_hot_low(san) ? TRACK : IDLE;
        end else if (state_q == TRACK && cnt == CNT_CAP) begin
            capture = 1'b1;
            state_d = CAPTURED;
        end
    end

    seg7_pattern_decode u_decode (
        .seg    (sseg),
        .hit    (hit),
        .nibble (nibble)
    );

    // Publishing reads the pre-edge digit registers, so a capture on the same edge joins the next frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dig_q       <= '0;
            derr_q      <= '0;
            seen        <= '0;
            value       <= '0;
            err         <= '0;
            frame_valid <= 1'b0;
`ifdef SEG7_SCAN_DP_EN
            ddp_q       <= '0;
            dp_out      <= '0;
`endif
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                value <= dig_q;
                err   <= derr_q;
`ifdef SEG7_SCAN_DP_EN
                dp_out <= ddp_q;
`endif
            end
            seen <= (frame_done ? 4'b0000 : seen) | (capture ? sel : 4'b0000);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture && sel[i]) begin
                    dig_q[4*i +: 4] <= nibble;
                    derr_q[i]       <= ~hit;
`ifdef SEG7_SCAN_DP_EN
                    ddp_q[i]        <= ~sdp;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - self-checking bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    localparam int S = 16;

    localparam logic [6:0] REF_PAT [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] BAD   = 7'b1111110;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  seg_d = 7'b1111111;
    logic [3:0]  an_d = 4'b1111;
    logic        dp_d = 1'b1;
    logic [15:0] value;
    logic [3:0]  err;
    logic        frame_valid;
    logic [3:0]  seen;
    logic [3:0]  dp_out;

    always #5 clk = ~clk;

    seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg         (seg_d),
        .an          (an_d),
`ifdef SEG7_SCAN_DP_EN
        .dp          (dp_d),
        .dp_out      (dp_out),
`endif
        .value       (value),
        .err         (err),
        .frame_valid (frame_valid),
        .seen        (seen)
    );

`ifndef SEG7_SCAN_DP_EN
    assign dp_out = 4'b0000;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: run length of the twice-delayed pin pattern decides captures
    logic [11:0] m_s1, m_s2, m_prev;
    int          m_run;
    logic [15:0] m_dig, m_val;
    logic [3:0]  m_derr, m_err, m_seen, m_ddp, m_dp;
    logic        m_fv;

    int          fv_cnt;
    logic [15:0] fv_val;
    logic [3:0]  fv_err, fv_dp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_prev = '0; m_run = 1;
        m_dig = '0; m_val = '0; m_derr = '0; m_err = '0;
        m_seen = '0; m_ddp = '0; m_dp = '0; m_fv = 1'b0;
    endtask

    task automatic model_edge();
        logic [11:0] d;
        int          idx;
        int          nib;
        d = m_s2;
        m_s2 = m_s1;
        m_s1 = {dp_d, an_d, seg_d};
        if (d == m_prev) m_run = (m_run < 1000000) ? m_run + 1 : m_run;
        else m_run = 1;
        m_prev = d;
        m_fv = (m_seen == 4'hF);
        if (m_fv) begin
            m_val = m_dig; m_err = m_derr; m_dp = m_ddp; m_seen = 4'h0;
        end
        if (m_run == S + 1 && $countones(~d[10:7]) == 1) begin
            idx = 0;
            for (int k = 0; k < 4; k++) if (!d[7+k]) idx = k;
            nib = -1;
            for (int k = 0; k < 16; k++) if (REF_PAT[k] == d[6:0]) nib = k;
            m_dig[4*idx +: 4] = (nib < 0) ? 4'h0 : 4'(nib);
            m_derr[idx] = (nib < 0);
            m_ddp[idx] = ~d[11];
            m_seen[idx] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset(); else model_edge();
        #1;
        chk("value", value, m_val);
        chk("err", err, m_err);
        chk("frame_valid", frame_valid, m_fv);
        chk("seen", seen, m_seen);
`ifdef SEG7_SCAN_DP_EN
        chk("dp_out", dp_out, m_dp);
`endif
        if (frame_valid) begin
            fv_cnt++; fv_val = value; fv_err = err; fv_dp = dp_out;
        end
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        an_d = a; seg_d = s;
        repeat (n) tick();
    endtask

    typedef struct {
        logic [6:0]  s [4];
        logic [15:0] v;
        logic [3:0]  e;
    } frame_vec_t;

    frame_vec_t tbl [5];

    initial begin
        tbl[0].s = '{REF_PAT[3], REF_PAT[10], REF_PAT[0], REF_PAT[15]};
        tbl[0].v = 16'hF0A3; tbl[0].e = 4'b0000;
        tbl[1].s = '{REF_PAT[0], REF_PAT[1], REF_PAT[2], REF_PAT[3]};
        tbl[1].v = 16'h3210; tbl[1].e = 4'b0000;
        tbl[2].s = '{REF_PAT[8], REF_PAT[9], REF_PAT[11], REF_PAT[12]};
        tbl[2].v = 16'hCB98; tbl[2].e = 4'b0000;
        tbl[3].s = '{REF_PAT[4], BLANK, REF_PAT[13], REF_PAT[14]};
        tbl[3].v = 16'hED04; tbl[3].e = 4'b0010;
        tbl[4].s = '{REF_PAT[7], REF_PAT[6], REF_PAT[5], BAD};
        tbl[4].v = 16'h0567; tbl[4].e = 4'b1000;

        model_reset();
        fv_cnt = 0; fv_val = '0; fv_err = '0; fv_dp = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("reset_value", value, 16'h0);
        chk("reset_err", err, 4'h0);
        chk("reset_fv", frame_valid, 1'b0);
        chk("reset_seen", seen, 4'h0);

        for (int f = 0; f < 5; f++) begin
            fv_cnt = 0;
            for (int i = 0; i < 4; i++) hold(~(4'b0001 << i), tbl[f].s[i], 20);
            hold(4'b1111, BLANK, 3);
            chk("tbl_fv_count", fv_cnt, 1);
            chk("tbl_value", fv_val, tbl[f].v);
            chk("tbl_err", fv_err, tbl[f].e);
        end

        fv_cnt = 0;
        hold(4'b1110, REF_PAT[5], 10);
        hold(4'b1111, BLANK, 2);
        chk("short_hold_seen", seen, 4'b0000);
        hold(4'b1101, REF_PAT[1], 20);
        hold(4'b1011, BLANK, 20);
        hold(4'b0111, REF_PAT[2], 20);
        hold(4'b1110, REF_PAT[4], 20);
        hold(4'b1111, BLANK, 3);
        chk("glitch_fv_count", fv_cnt, 1);
        chk("glitch_value", fv_val, 16'h2014);
        chk("glitch_err", fv_err, 4'b0100);

        fv_cnt = 0;
        hold(4'b1110, REF_PAT[9], 20);
        chk("pre_two_anode_seen", seen, 4'b0001);
        hold(4'b1100, REF_PAT[8], 40);
        chk("two_anode_seen", seen, 4'b0001);
        hold(4'b1101, REF_PAT[5], 20);
        hold(4'b1011, REF_PAT[12], 20);
        hold(4'b1101, REF_PAT[7], 20);
        chk("rescan_seen", seen, 4'b0111);
        hold(4'b0111, REF_PAT[14], 20);
        hold(4'b1111, BLANK, 3);
        chk("rescan_fv_count", fv_cnt, 1);
        chk("rescan_value", fv_val, 16'hEC79);

        hold(4'b1110, REF_PAT[1], 20);
        hold(4'b1101, REF_PAT[2], 20);
        hold(4'b1011, REF_PAT[3], 20);
        chk("pre_reset_seen", seen, 4'b0111);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset_value", value, 16'h0);
        chk("async_reset_seen", seen, 4'h0);
        chk("async_reset_err", err, 4'h0);
        chk("async_reset_fv", frame_valid, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        fv_cnt = 0;
        hold(4'b0111, REF_PAT[4], 20);
        hold(4'b1110, REF_PAT[5], 20);
        hold(4'b1101, REF_PAT[6], 20);
        chk("post_reset_no_fv", fv_cnt, 0);
        hold(4'b1011, REF_PAT[7], 20);
        hold(4'b1111, BLANK, 3);
        chk("post_reset_fv_count", fv_cnt, 1);
        chk("post_reset_value", fv_val, 16'h4765);

`ifdef SEG7_SCAN_DP_EN
        fv_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            dp_d = (i == 2) ? 1'b0 : 1'b1;
            hold(~(4'b0001 << i), REF_PAT[i], 20);
        end
        dp_d = 1'b1;
        hold(4'b1111, BLANK, 3);
        chk("dp_fv_count", fv_cnt, 1);
        chk("dp_out", fv_dp, 4'b0100);
`endif

        for (int r = 0; r < 300; r++) begin
            logic [3:0] a;
            logic [6:0] s;
            case ($urandom_range(0, 5))
                0, 1, 2, 3: a = ~(4'b0001 << $urandom_range(0, 3));
                4:          a = 4'b1111;
                default:    a = 4'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) s = 7'($urandom);
            else s = REF_PAT[$urandom_range(0, 15)];
`ifdef SEG7_SCAN_DP_EN
            dp_d = 1'($urandom);
`endif
            hold(a, s, $urandom_range(1, 24));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
